// File: rtl/ldl_ram_pkg.sv
// ldl_ram_pkg: shared types and helpers for the ldl_ram_p2_be RAM family.
//   ram_clr_st_e : post-reset clear sequencer states
//   RDLAT_MIN/MAX: legal read-latency range
//   merge_be()   : lane-wise merge of a new word into an old word
package ldl_ram_pkg;

  typedef enum logic {CLEAR, READY} ram_clr_st_e;

  localparam int RDLAT_MIN = 1;
  localparam int RDLAT_MAX = 2;

  // merge_be works on a fixed maximum word; callers size-cast in and out.
  localparam int MRG_W   = 256;
  localparam int MRG_NB  = 32;
  localparam int MRG_NBW = 5;

  // Bit i belongs to lane i/bw; a set enable takes the new bit, else keeps old.
  function automatic logic [MRG_W-1:0] merge_be(input logic [MRG_W-1:0]  old_w,
                                                input logic [MRG_W-1:0]  new_w,
                                                input logic [MRG_NB-1:0] be,
                                                input int                bw);
    logic [MRG_W-1:0] res;
    int lane;
    for (int i = 0; i < MRG_W; i++) begin
      lane = i / bw;
      if (lane < MRG_NB) res[i] = be[lane[MRG_NBW-1:0]] ? new_w[i] : old_w[i];
      else               res[i] = old_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/ldl_ram_core.sv
// ldl_ram_core: plain storage array, one lane-enabled write port and one
// registered read port. No reset; read-during-write returns the old word.
//   clk   : clock
//   we/be/waddr/wdata : write strobe, lane enables, address, data
//   re/raddr          : read strobe and address
//   rdata             : registered read data, updated only when re
module ldl_ram_core
  import ldl_ram_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4,
  parameter int BWIDTH = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [DWIDTH/BWIDTH-1:0]   be,
  input  logic [AWIDTH-1:0]          waddr,
  input  logic [DWIDTH-1:0]          wdata,
  input  logic                       re,
  input  logic [AWIDTH-1:0]          raddr,
  output logic [DWIDTH-1:0]          rdata
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= DWIDTH'(merge_be(MRG_W'(mem[waddr]), MRG_W'(wdata),
                                     MRG_NB'(be), BWIDTH));
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/ldl_ram_p2_be.sv
// ldl_ram_p2_be: simple dual-port RAM with byte enables, selectable
// read-during-write result, 1/2-cycle read latency and post-reset clear.
//   clk, rst            : clock, synchronous active-high reset
//   wea/bea/addra/dina  : write request, lane enables, address, data
//   reb/addrb           : read request and address
//   doutb/doutb_vld     : read data and its valid strobe
//   busy                : clear sequence running, user requests ignored
//
// Clear FSM:
//   state | meaning
//   CLEAR | writing zero to mem[cnt], one word per cycle, busy high
//   READY | normal read/write operation
module ldl_ram_p2_be
  import ldl_ram_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 4,
  parameter int BWIDTH     = 8,
  parameter int RDLAT      = 1,
  parameter int RDW_MODE   = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wea,
  input  logic [DWIDTH/BWIDTH-1:0]   bea,
  input  logic [AWIDTH-1:0]          addra,
  input  logic [DWIDTH-1:0]          dina,
  input  logic                       reb,
  input  logic [AWIDTH-1:0]          addrb,
  output logic [DWIDTH-1:0]          doutb,
  output logic                       doutb_vld,
  output logic                       busy
);

  localparam int NB = DWIDTH / BWIDTH;

  if ((DWIDTH % BWIDTH) != 0) begin : g_err_bwidth
    $error("ldl_ram_p2_be: DWIDTH must be a multiple of BWIDTH");
  end
  if (RDLAT < RDLAT_MIN || RDLAT > RDLAT_MAX) begin : g_err_rdlat
    $error("ldl_ram_p2_be: RDLAT must be 1 or 2");
  end
  if (DWIDTH > MRG_W || NB > MRG_NB) begin : g_err_width
    $error("ldl_ram_p2_be: word too wide for merge_be");
  end

  ram_clr_st_e       state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              clr_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = ~rst;
        cnt_d  = cnt_q + AWIDTH'(1);
        if (&cnt_q) state_d = READY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_CLEAR != 0) ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == CLEAR);

  logic usr_we, usr_re;
  assign usr_we = wea & ~busy & ~rst;
  assign usr_re = reb & ~busy & ~rst;

  // Clear writes own the port while busy; user requests are masked then.
  logic              core_we;
  logic [NB-1:0]     core_be;
  logic [AWIDTH-1:0] core_waddr;
  logic [DWIDTH-1:0] core_wdata;
  logic [DWIDTH-1:0] core_rdata;

  assign core_we    = clr_we | usr_we;
  assign core_be    = busy ? '1    : bea;
  assign core_waddr = busy ? cnt_q : addra;
  assign core_wdata = busy ? '0    : dina;

  ldl_ram_core #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .BWIDTH (BWIDTH)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .be    (core_be),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .re    (usr_re),
    .raddr (addrb),
    .rdata (core_rdata)
  );

  // The core returns the pre-write word; in new-data mode the colliding
  // write is captured alongside the read and merged over it afterwards.
  logic              hit_q;
  logic [NB-1:0]     be_q;
  logic [DWIDTH-1:0] din_q;
  logic [DWIDTH-1:0] rd1;

  always_ff @(posedge clk) begin
    if (usr_re) begin
      hit_q <= (RDW_MODE != 0) && usr_we && (addra == addrb);
      be_q  <= bea;
      din_q <= dina;
    end
  end

  assign rd1 = hit_q ? DWIDTH'(merge_be(MRG_W'(core_rdata), MRG_W'(din_q),
                                        MRG_NB'(be_q), BWIDTH))
                     : core_rdata;

  logic v1_q;

  always_ff @(posedge clk) begin
    if (rst) v1_q <= 1'b0;
    else     v1_q <= usr_re;
  end

  if (RDLAT == 2) begin : g_lat2
    logic [DWIDTH-1:0] dout2_q;
    logic              v2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout2_q <= '0;
        v2_q    <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) dout2_q <= rd1;
      end
    end

    assign doutb     = dout2_q;
    assign doutb_vld = v2_q;
  end else begin : g_lat1
    // The core read register has no reset; force zero until the first read.
    logic out_clr_q;

    always_ff @(posedge clk) begin
      if (rst)         out_clr_q <= 1'b1;
      else if (usr_re) out_clr_q <= 1'b0;
    end

    assign doutb     = out_clr_q ? '0 : rd1;
    assign doutb_vld = v1_q;
  end

endmodule

// File: tb/tb_ldl_ram_p2_be.sv
// Scoreboard bench: two instances share stimulus, one with RDLAT=1/old-data
// and one with RDLAT=2/new-data read-during-write.
module tb_ldl_ram_p2_be;

  logic        clk = 1'b0;
  logic        rst, wea, reb;
  logic [3:0]  bea, addra, addrb;
  logic [31:0] dina;
  logic [31:0] doutb0, doutb1;
  logic        vld0, vld1, busy0, busy1;

  always #5 clk = ~clk;

  ldl_ram_p2_be #(.RDLAT(1), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
    .reb(reb), .addrb(addrb), .doutb(doutb0), .doutb_vld(vld0), .busy(busy0)
  );

  ldl_ram_p2_be #(.RDLAT(2), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
    .reb(reb), .addrb(addrb), .doutb(doutb1), .doutb_vld(vld1), .busy(busy1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sq0[$];
  exp_t        sq1[$];
  exp_t        e0, e1;
  logic [31:0] ref_mem [16];
  bit          model_busy;

  function automatic logic [31:0] lane_mix(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[l*8 +: 8] = be[l] ? new_w[l*8 +: 8] : old_w[l*8 +: 8];
    return r;
  endfunction

  // Results are due at a fixed cycle; anything else is a miscompare.
  always @(negedge clk) begin
    if (sq0.size() > 0 && sq0[0].due == cyc) begin
      e0 = sq0.pop_front();
      chk("vld0", vld0, 1);
      chk("rd0", doutb0, e0.data);
    end else if (vld0) chk("spur_vld0", vld0, 0);
    if (sq1.size() > 0 && sq1[0].due == cyc) begin
      e1 = sq1.pop_front();
      chk("vld1", vld1, 1);
      chk("rd1", doutb1, e1.data);
    end else if (vld1) chk("spur_vld1", vld1, 0);
  end

  task automatic idle();
    wea = 1'b0; reb = 1'b0; bea = 4'h0; addra = 4'h0; addrb = 4'h0; dina = 32'h0;
  endtask

  task automatic op(input logic w, input logic [3:0] be, input logic [3:0] wa,
                    input logic [31:0] di, input logic r, input logic [3:0] ra);
    exp_t e;
    wea = w; bea = be; addra = wa; dina = di; reb = r; addrb = ra;
    if (!model_busy) begin
      if (r) begin
        e.data = ref_mem[ra];
        e.due  = cyc + 1;
        sq0.push_back(e);
        e.data = (w && wa == ra) ? lane_mix(ref_mem[ra], di, be) : ref_mem[ra];
        e.due  = cyc + 2;
        sq1.push_back(e);
      end
      if (w) ref_mem[wa] = lane_mix(ref_mem[wa], di, be);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    idle();
    while (sq0.size() > 0 && sq0[$].due > cyc) void'(sq0.pop_back());
    while (sq1.size() > 0 && sq1[$].due > cyc) void'(sq1.pop_back());
    model_busy = 1'b1;
  endtask

  task automatic clear_wait(input bit poke);
    for (int i = 0; i < 16; i++) begin
      chk("busy0", busy0, 1);
      chk("busy1", busy1, 1);
      if (poke) op(1'b1, 4'hF, i[3:0], 32'hDEAD0000 | i, 1'b1, i[3:0]);
      else      @(negedge clk);
    end
    chk("busy0_end", busy0, 0);
    chk("busy1_end", busy1, 0);
    model_busy = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, i[3:0]);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    model_busy = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout0", doutb0, 0);
    chk("rst_dout1", doutb1, 0);
    chk("rst_vld0", vld0, 0);
    chk("rst_vld1", vld1, 0);
    chk("rst_busy0", busy0, 1);
    chk("rst_busy1", busy1, 1);
    rst = 1'b0;
    clear_wait(1'b0);
    read_all();

    // lane enables, including a no-op write with no lanes set
    op(1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0);
    op(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, 4'd0);
    op(1'b1, 4'b0000, 4'd3, 32'h55555555, 1'b0, 4'd0);
    op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);

    // same-address read-during-write, then a plain re-read
    op(1'b1, 4'hF, 4'd5, 32'h01020304, 1'b0, 4'd0);
    op(1'b1, 4'b1000, 4'd5, 32'hFF000000, 1'b1, 4'd5);
    op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5);

    // different addresses in one cycle
    op(1'b1, 4'hF, 4'd9, 32'h99999999, 1'b1, 4'd3);
    op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd9);

    // streaming writes then back-to-back reads
    for (int i = 0; i < 8; i++)
      op(1'b1, 4'hF, i[3:0], (32'(i) * 32'h01010101) ^ 32'hA5A50000, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, i[3:0]);
    repeat (4) @(negedge clk);
    chk("hold0", doutb0, ref_mem[7]);
    chk("hold1", doutb1, ref_mem[7]);

    // reset in the cycle after a read, then requests during the clear
    op(1'b1, 4'hF, 4'd6, 32'h66666666, 1'b0, 4'd0);
    op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd6);
    assert_rst();
    @(negedge clk);
    chk("rr_dout0", doutb0, 0);
    chk("rr_dout1", doutb1, 0);
    chk("rr_vld1", vld1, 0);
    rst = 1'b0;
    clear_wait(1'b1);
    read_all();

    // reset pulsed in the middle of the clear restarts it
    op(1'b1, 4'hF, 4'd2, 32'h22222222, 1'b0, 4'd0);
    assert_rst();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("mid_busy0", busy0, 1);
      @(negedge clk);
    end
    assert_rst();
    @(negedge clk);
    chk("mid_rst_busy0", busy0, 1);
    chk("mid_rst_busy1", busy1, 1);
    rst = 1'b0;
    clear_wait(1'b0);
    read_all();

    repeat (4) @(negedge clk);
    chk("left0", sq0.size(), 0);
    chk("left1", sq1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
